// File: rtl/core_ctrl_pkg.sv
// Shared control constants for the compute core, its sequencer and the host register file.
package core_ctrl_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SA3    = 2'd1;
  localparam logic [1:0] MODE_SA2    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Host-side request/response channel of the core sequencer.
interface core_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_c11;
  logic [7:0]       rsp_c12;
  logic [7:0]       rsp_c21;
  logic [7:0]       rsp_c22;
  logic             rsp_err;
  logic [CNT_W-1:0] rsp_cycles;

  modport master (
    output req_valid, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_c11, rsp_c12, rsp_c21, rsp_c22, rsp_err, rsp_cycles
  );

  modport slave (
    input  req_valid, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_c11, rsp_c12, rsp_c21, rsp_c22, rsp_err, rsp_cycles
  );

endinterface

// File: rtl/core_sequencer.sv
// Sequences one convolution: send phase, then the selected engine, then holds the result
// with status and a saturating SEND+RUN cycle count until the host takes it.
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.slave  host,
  output logic             active_send,
  output logic             active_single,
  output logic             active_sa3,
  output logic             active_sa2,
  input  logic             done_send,
  input  logic             done_single,
  input  logic             done_sa3,
  input  logic             done_sa2,
  input  logic [7:0]       c11,
  input  logic [7:0]       c12,
  input  logic [7:0]       c21,
  input  logic [7:0]       c22
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  seq_state_t       state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0][7:0]  rsp_c_reg, rsp_c_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic             engine_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_SINGLE;
      cnt_reg    <= '0;
      rsp_c_reg  <= '0;
      err_reg    <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      rsp_c_reg  <= rsp_c_next;
      err_reg    <= err_next;
      cycles_reg <= cycles_next;
    end
  end

  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Only the done of the latched engine counts; the others are noise in RUN.
  always_comb begin
    engine_done = 1'b0;
    case (mode_reg)
      MODE_SINGLE: engine_done = done_single;
      MODE_SA3:    engine_done = done_sa3;
      MODE_SA2:    engine_done = done_sa2;
      default:     engine_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    cnt_next    = cnt_reg;
    rsp_c_next  = rsp_c_reg;
    err_next    = err_reg;
    cycles_next = cycles_reg;
    case (state_reg)
      ST_IDLE: begin
        if (host.req_valid) begin
          mode_next = host.req_mode;
          cnt_next  = '0;
          if (host.req_mode == MODE_RSVD) begin
            state_next  = ST_RESP;
            rsp_c_next  = '0;
            err_next    = 1'b1;
            cycles_next = '0;
          end else begin
            state_next = ST_SEND;
          end
        end
      end
      ST_SEND, ST_RUN: begin
        cnt_next = cnt_inc;
        // A done in the same cycle as the timeout takes priority.
        if (state_reg == ST_SEND && done_send) begin
          state_next = ST_RUN;
        end else if (state_reg == ST_RUN && engine_done) begin
          state_next  = ST_RESP;
          rsp_c_next  = {c22, c21, c12, c11};
          err_next    = 1'b0;
          cycles_next = cnt_reg;
        end else if (cnt_reg >= TIMEOUT_CNT) begin
          state_next  = ST_RESP;
          rsp_c_next  = '0;
          err_next    = 1'b1;
          cycles_next = TIMEOUT_CNT;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes depend on registers only, so they carry no input-to-output path.
  assign active_send   = (state_reg == ST_SEND);
  assign active_single = (state_reg == ST_RUN) && (mode_reg == MODE_SINGLE);
  assign active_sa3    = (state_reg == ST_RUN) && (mode_reg == MODE_SA3);
  assign active_sa2    = (state_reg == ST_RUN) && (mode_reg == MODE_SA2);

  assign host.req_ready  = (state_reg == ST_IDLE);
  assign host.rsp_valid  = (state_reg == ST_RESP);
  assign host.rsp_c11    = rsp_c_reg[0];
  assign host.rsp_c12    = rsp_c_reg[1];
  assign host.rsp_c21    = rsp_c_reg[2];
  assign host.rsp_c22    = rsp_c_reg[3];
  assign host.rsp_err    = err_reg;
  assign host.rsp_cycles = cycles_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: behavioural core model, stalling consumer and
// a negedge monitor that compares each response with the expectation queued at request time.
module tb_core_sequencer;
  import core_ctrl_pkg::*;

  localparam int TMO = 20;
  localparam int CW  = 16;

  typedef struct {
    logic [3:0][7:0] c;
    logic            err;
    int              cycles;
    logic [3:0]      mask;
    int              lat;
    logic [1:0]      mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_sequencer_if #(.CNT_W(CW)) bus ();

  logic       active_send, active_single, active_sa3, active_sa2;
  logic       done_send, done_single, done_sa3, done_sa2;
  logic [7:0] c11, c12, c21, c22;
  logic [3:0] act;

  core_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus),
    .active_send  (active_send),
    .active_single(active_single),
    .active_sa3   (active_sa3),
    .active_sa2   (active_sa2),
    .done_send    (done_send),
    .done_single  (done_single),
    .done_sa3     (done_sa3),
    .done_sa2     (done_sa2),
    .c11          (c11),
    .c12          (c12),
    .c21          (c21),
    .c22          (c22)
  );

  assign act = {active_sa2, active_sa3, active_single, active_send};

  // Core model: done_send registered from active_send, engine done after core_lat cycles.
  int         core_lat  = 9;
  bit         core_hang = 1'b0;
  bit         core_spur = 1'b0;
  logic [7:0] c_base [4];
  int         eng_cnt;
  logic       done_send_q;
  logic [7:0] mode_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_send_q <= 1'b0;
      eng_cnt     <= 0;
    end else begin
      done_send_q <= active_send;
      eng_cnt     <= (active_single || active_sa3 || active_sa2) ? eng_cnt + 1 : 0;
    end
  end

  always_comb mode_off = active_sa3 ? 8'h40 : (active_sa2 ? 8'h80 : 8'h00);

  assign done_send   = done_send_q;
  assign done_single = (active_single && !core_hang && eng_cnt == core_lat) ||
                       (core_spur && active_sa3 && eng_cnt == 4);
  assign done_sa2    = (active_sa2 && !core_hang && eng_cnt == core_lat) ||
                       (core_spur && active_sa3 && eng_cnt == 2);
  assign done_sa3    = active_sa3 && !core_hang && eng_cnt == core_lat;
  assign c11 = c_base[0] + 8'(eng_cnt) + mode_off;
  assign c12 = c_base[1] + 8'(eng_cnt) + mode_off;
  assign c21 = c_base[2] + 8'(eng_cnt) + mode_off;
  assign c22 = c_base[3] + 8'(eng_cnt) + mode_off;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [$];
  int   stall_cfg = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer: holds rsp_ready low for stall_cfg cycles of each response.
  initial begin
    int stalled = 0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.rsp_valid) stalled = 0;
      if (bus.rsp_valid && stalled < stall_cfg) begin
        bus.rsp_ready = 1'b0;
        stalled++;
      end else begin
        bus.rsp_ready = 1'b1;
      end
    end
  end

  // Monitor
  bit         pending = 1'b0;
  bit         in_resp = 1'b0;
  bit         multi   = 1'b0;
  int         wait_cnt = 0;
  int         n_rsp = 0;
  logic [3:0] seen_mask = '0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      in_resp = 1'b0;
    end else begin
      if (pending) begin
        wait_cnt++;
        seen_mask |= act;
        if ($countones(act) > 1) multi = 1'b1;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          mon_e = sb[0];
          if (!in_resp) begin
            in_resp = 1'b1;
            check_eq("latency", 32'(wait_cnt), 32'(mon_e.lat));
            check_eq("actives_in_resp", 32'(act), 32'd0);
          end
          if (bus.rsp_ready) begin
            check_eq("rsp_c11", 32'(bus.rsp_c11), 32'(mon_e.c[0]));
            check_eq("rsp_c12", 32'(bus.rsp_c12), 32'(mon_e.c[1]));
            check_eq("rsp_c21", 32'(bus.rsp_c21), 32'(mon_e.c[2]));
            check_eq("rsp_c22", 32'(bus.rsp_c22), 32'(mon_e.c[3]));
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            check_eq("rsp_cycles", 32'(bus.rsp_cycles), 32'(mon_e.cycles));
            check_eq("strobe_mask", 32'(seen_mask), 32'(mon_e.mask));
            check_eq("multi_active", 32'(multi), 32'd0);
            $display("rsp %0d: mode=%0d c=%h_%h_%h_%h err=%0b cycles=%0d latency=%0d", n_rsp,
                     mon_e.mode, bus.rsp_c11, bus.rsp_c12, bus.rsp_c21, bus.rsp_c22,
                     bus.rsp_err, bus.rsp_cycles, wait_cnt);
            n_rsp++;
            void'(sb.pop_front());
            pending = 1'b0;
            in_resp = 1'b0;
          end else begin
            check_eq("stall_rsp_c", 32'({bus.rsp_c22, bus.rsp_c21, bus.rsp_c12, bus.rsp_c11}),
                     32'(mon_e.c));
            check_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
          end
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        pending   = 1'b1;
        wait_cnt  = 0;
        seen_mask = '0;
        multi     = 1'b0;
        in_resp   = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] mode);
    exp_t       e;
    logic [7:0] off;
    bit         accepted;
    e.mode = mode;
    off = (mode == MODE_SA3) ? 8'h40 : ((mode == MODE_SA2) ? 8'h80 : 8'h00);
    if (mode == MODE_RSVD) begin
      e.c = '0; e.err = 1'b1; e.cycles = 0; e.mask = 4'b0000; e.lat = 1;
    end else if (core_hang) begin
      e.c = '0; e.err = 1'b1; e.cycles = TMO;
      e.mask = 4'b0001 | (4'b0010 << mode); e.lat = TMO + 2;
    end else begin
      for (int i = 0; i < 4; i++) e.c[i] = c_base[i] + 8'(core_lat) + off;
      e.err = 1'b0; e.cycles = 2 + core_lat;
      e.mask = 4'b0001 | (4'b0010 << mode); e.lat = 4 + core_lat;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    accepted = 1'b0;
    for (int k = 0; k < 400 && !accepted; k++) begin
      @(negedge clk);
      if (bus.req_ready) accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!accepted) begin
      check_eq("accept_timeout", 32'(accepted), 32'd1);
      void'(sb.pop_back());
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_active;
    bus.req_valid = 1'b0;
    bus.req_mode  = MODE_SINGLE;
    c_base = '{8'h08, 8'h19, 8'h2A, 8'h3B};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_actives", 32'(act), 32'd0);
    check_eq("rst_rsp_c", 32'({bus.rsp_c22, bus.rsp_c21, bus.rsp_c12, bus.rsp_c11}), 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_rsp_cycles", 32'(bus.rsp_cycles), 32'd0);
    #3 rst = 1'b0;

    // Single mode, result 11_22_33_44 after 9 engine cycles.
    core_lat = 9;
    issue(MODE_SINGLE);
    drain();

    // SA3 then SA2 queued behind it, each response stalled for 3 cycles.
    stall_cfg = 3;
    core_lat  = 6;
    issue(MODE_SA3);
    issue(MODE_SA2);
    drain();
    stall_cfg = 0;

    // Reserved mode.
    issue(MODE_RSVD);
    drain();

    // Engine never finishes.
    core_hang = 1'b1;
    issue(MODE_SA3);
    drain();
    core_hang = 1'b0;

    // Foreign done pulses while running SA3.
    core_spur = 1'b1;
    core_lat  = 8;
    issue(MODE_SA3);
    drain();
    core_spur = 1'b0;

    // Reset in the middle of RUN.
    core_lat = 15;
    issue(MODE_SINGLE);
    seen_active = 1'b0;
    for (int k = 0; k < 50 && !seen_active; k++) begin
      @(negedge clk);
      if (active_single) seen_active = 1'b1;
    end
    check_eq("run_reached", 32'(seen_active), 32'd1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_actives", 32'(act), 32'd0);
    check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("midrst_rsp_c", 32'({bus.rsp_c22, bus.rsp_c21, bus.rsp_c12, bus.rsp_c11}), 32'd0);
    void'(sb.pop_back());
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("postrst_actives", 32'(act), 32'd0);
    end
    core_lat = 5;
    issue(MODE_SINGLE);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Controller that sequences one convolution on the compute core. It accepts a mode request from the host or DMA side using a ready/valid handshake, then drives the core's send phase followed by the selected engine (single PE, 3x3 systolic, or 2x2 systolic). It captures the 2x2 result on the engine's done and returns it with status and a cycle count. It sits between the host-side command interface and the core, and owns every active_* strobe into the core.

## Interface
Parameters:
- TIMEOUT, 1023: maximum number of SEND+RUN cycles before the operation aborts.
- CNT_W, 16: width of the cycle counter and of rsp_cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_mode  in  2  0=single, 1=sa3, 2=sa2, 3=reserved.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_c11, rsp_c12, rsp_c21, rsp_c22  out  8 each  captured result.
- rsp_err  out  1  illegal mode or timeout.
- rsp_cycles  out  CNT_W  number of SEND+RUN cycles, saturating.
- active_send, active_single, active_sa3, active_sa2  out  1 each  core strobes.
- done_send, done_single, done_sa3, done_sa2  in  1 each  core completion flags.
- c11, c12, c21, c22  in  8 each  core result bus; valid only while an engine active is high.

The A and B operands go directly from the host to the core. The host holds them stable while req_ready=0.

## Operation
- States: IDLE, SEND, RUN, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&req_ready: latch mode and clear the counter.
  - If mode=3: go to RESP with rsp_err=1 and all rsp_c = 0. No active strobe is ever raised.
  - Otherwise go to SEND.
- SEND
  - active_send=1.
  - When done_send=1, go to RUN.
  - done_single, done_sa3 and done_sa2 are ignored in this state.
- RUN
  - Exactly one of active_single, active_sa3 or active_sa2 is 1, per the latched mode. active_send=0.
  - When the done for the latched mode is 1, capture c11..c22 on that same edge into rsp_c*, set rsp_err=0, and go to RESP.
  - done flags for other modes, and a done_send still trailing from SEND, are ignored.
- RESP
  - All active strobes are 0. rsp_valid=1.
  - rsp_c*, rsp_err and rsp_cycles stay stable until rsp_valid&rsp_ready, then go to IDLE.
  - req_ready=0.
- Counter
  - Increments once per cycle spent in SEND or RUN.
  - Saturates at 2^CNT_W-1.
  - Copied to rsp_cycles on entry to RESP.
- Timeout
  - If the counter reaches TIMEOUT while in SEND or RUN, go to RESP with rsp_err=1, rsp_c*=0 and rsp_cycles=TIMEOUT.
  - Timeout and done in the same cycle: done wins.
- Strobes are decoded from the state register and the latched mode only, with no combinational path from the inputs, so the strobes are glitch-free.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, all active_*=0, rsp_c*=0, rsp_err=0, rsp_cycles=0.
- Request accepted at edge 0.
  - SEND holds during cycle 1.
  - The core registers done_send, so done_send is high in cycle 2.
  - RUN starts at cycle 3.
  - Minimum request-to-rsp_valid latency with an ideal core is therefore 3 + engine latency + 1.
- Illegal mode: rsp_valid=1 in the cycle after acceptance.
- RESP to IDLE takes one edge after the rsp handshake. No new request is accepted in that same cycle (no bypass).
- rst asserted in any state: immediate return to reset values. All actives drop asynchronously and no response is produced.

## Structure
- Shared package core_ctrl_pkg holds:
  - MODE_SINGLE=2'd0, MODE_SA3=2'd1, MODE_SA2=2'd2, MODE_RSVD=2'd3.
  - The state encoding (IDLE, SEND, RUN, RESP).
  - These constants are reused by the core and by the host register file.
- Single module, no sub-module. The counter and the FSM fit in one file.

## Test plan
- Single mode, bench core raises done_single 9 cycles after active_single, with c={0x11,0x22,0x33,0x44} -> rsp_c matches, rsp_err=0, rsp_cycles=2+9, only active_send then active_single were high.
- Mode 1 followed back-to-back by mode 2, with rsp_ready low for 3 cycles after the first response -> rsp_c stable while stalled, req_ready=0 until the handshake, then the second request runs with active_sa2 only.
- req_mode=3 -> rsp_valid one cycle after acceptance, rsp_err=1, rsp_c=0, no active strobe ever high.
- TIMEOUT=20, core never asserts done_sa3 -> rsp_err=1, rsp_cycles=20, active_sa3 drops on RESP entry, rsp_c=0.
- done_sa2 and done_single pulsed while running mode 1, then done_sa3 -> only the done_sa3 cycle's c values are captured.
- rst pulsed mid-RUN -> all actives low immediately, no rsp_valid, next request runs normally with the counter cleared.
